pipe_de_reg: RTL and testbench

- D→E pipeline register of the 5-stage MIPS core; it feeds the E-stage control decoder and the ALU.
- Latches the decoded-stage instruction, PCs, forwarded operands and extended immediate.
- Precomputes the three 3-bit compare vectors consumed by E-stage control (slt/sltu/slti/sltiu selection), so no comparator sits on the E-stage critical path.
- Implements bubble insertion (load-use stall, branch/jump flush), whole-pipe freeze, and two performance counters.

---
 rtl/mips_defs.sv | 22 ++
 rtl/cmp3.sv | 22 ++
 rtl/pipe_de_reg.sv | 90 +++++++++
 tb/tb_pipe_de_reg.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mips_defs.sv
// Shared MIPS encodings and compare-vector layout used by the D->E pipeline register.
package mips_defs;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_SLTI    = 6'b001010;
  localparam logic [5:0] OP_SLTIU   = 6'b001011;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SLT     = 6'b101010;
  localparam logic [5:0] FN_SLTU    = 6'b101011;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  localparam logic [31:0] NOP_IR = 32'h0;

  typedef enum logic {SLOT_BUBBLE = 1'b0, SLOT_VALID = 1'b1} slot_e;

  function automatic logic is_icmp(input logic [5:0] op);
    return (op == OP_SLTI) || (op == OP_SLTIU);
  endfunction
endpackage

// File: rtl/cmp3.sv
// Three-way comparator: one-hot {gt, eq, lt} of a versus b, signed or unsigned.
module cmp3
  import mips_defs::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         is_signed,
  output logic [2:0]   cmp
);
  logic lt, eq;

  always_comb begin
    lt  = is_signed ? ($signed(a) < $signed(b)) : (a < b);
    eq  = (a == b);
    cmp = '0;
    cmp[CMP_LT] = lt;
    cmp[CMP_EQ] = eq;
    cmp[CMP_GT] = !lt && !eq;
  end
endmodule

// File: rtl/pipe_de_reg.sv
// D->E pipeline register: latches D-stage state, precomputes E-stage compare
// vectors, handles bubble/freeze and counts bubbles and frozen cycles.
module pipe_de_reg
  import mips_defs::*;
#(
  parameter int W     = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             stall,
  input  logic             flush,
  input  logic [W-1:0]     IR_D,
  input  logic [W-1:0]     PC_D,
  input  logic [W-1:0]     PC8_D,
  input  logic [W-1:0]     RS_D,
  input  logic [W-1:0]     RT_D,
  input  logic [W-1:0]     EXT_D,
  output logic [W-1:0]     IR_E,
  output logic [W-1:0]     PC_E,
  output logic [W-1:0]     PC8_E,
  output logic [W-1:0]     RS_E,
  output logic [W-1:0]     RT_E,
  output logic [W-1:0]     EXT_E,
  output logic             valid_E,
  output logic [2:0]       A_B_SIGN_CMP,
  output logic [2:0]       A_0_SIGN_CMP,
  output logic [2:0]       A_B_UNSIGN_CMP,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);
  localparam logic [W-1:0] ZERO = '0;

  logic [W-1:0] b_op;
  logic [2:0]   ab_s, a0_s, ab_u;
  slot_e        slot_q;

  // slti/sltiu compare against the immediate; every other opcode uses rt.
  assign b_op = is_icmp(IR_D[W-1 -: 6]) ? EXT_D : RT_D;

  cmp3 #(.W(W)) u_ab_s (.a(RS_D), .b(b_op), .is_signed(1'b1), .cmp(ab_s));
  cmp3 #(.W(W)) u_a0_s (.a(RS_D), .b(ZERO), .is_signed(1'b1), .cmp(a0_s));
  cmp3 #(.W(W)) u_ab_u (.a(RS_D), .b(b_op), .is_signed(1'b0), .cmp(ab_u));

  always_ff @(posedge clk) begin
    if (reset) begin
      IR_E           <= NOP_IR[W-1:0];
      PC_E           <= '0;
      PC8_E          <= '0;
      RS_E           <= '0;
      RT_E           <= '0;
      EXT_E          <= '0;
      slot_q         <= SLOT_BUBBLE;
      A_B_SIGN_CMP   <= '0;
      A_0_SIGN_CMP   <= '0;
      A_B_UNSIGN_CMP <= '0;
      bubble_cnt     <= '0;
      freeze_cnt     <= '0;
    end else if (freeze) begin
      // stall/flush are re-asserted by the hazard unit once freeze drops
      freeze_cnt <= freeze_cnt + 1'b1;
    end else if (stall || flush) begin
      IR_E           <= NOP_IR[W-1:0];
      PC_E           <= '0;
      PC8_E          <= '0;
      RS_E           <= '0;
      RT_E           <= '0;
      EXT_E          <= '0;
      slot_q         <= SLOT_BUBBLE;
      A_B_SIGN_CMP   <= '0;
      A_0_SIGN_CMP   <= '0;
      A_B_UNSIGN_CMP <= '0;
      bubble_cnt     <= bubble_cnt + 1'b1;
    end else begin
      IR_E           <= IR_D;
      PC_E           <= PC_D;
      PC8_E          <= PC8_D;
      RS_E           <= RS_D;
      RT_E           <= RT_D;
      EXT_E          <= EXT_D;
      slot_q         <= SLOT_VALID;
      A_B_SIGN_CMP   <= ab_s;
      A_0_SIGN_CMP   <= a0_s;
      A_B_UNSIGN_CMP <= ab_u;
    end
  end

  assign valid_E = (slot_q == SLOT_VALID);
endmodule

// File: tb/tb_pipe_de_reg.sv
// Self-checking bench for pipe_de_reg: directed cases plus random traffic
// checked against a cycle-level behavioural model.
module tb_pipe_de_reg;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset, freeze, stall, flush;
  logic [W-1:0] IR_D, PC_D, PC8_D, RS_D, RT_D, EXT_D;
  logic [W-1:0] IR_E, PC_E, PC8_E, RS_E, RT_E, EXT_E;
  logic         valid_E;
  logic [2:0]   A_B_SIGN_CMP, A_0_SIGN_CMP, A_B_UNSIGN_CMP;
  logic [31:0]  bubble_cnt, freeze_cnt;

  logic [W-1:0] ir4, pc4, pc84, rs4, rt4, ext4;
  logic         v4;
  logic [2:0]   abs4, a0s4, abu4;
  logic [3:0]   bub4, frz4;

  int checks = 0;
  int failures = 0;

  // model state
  logic [W-1:0] m_ir, m_pc, m_pc8, m_rs, m_rt, m_ext;
  logic         m_v;
  logic [2:0]   m_abs, m_a0s, m_abu;
  int unsigned  m_bub, m_frz;

  always #5 clk = ~clk;

  pipe_de_reg #(.W(W), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .freeze(freeze), .stall(stall), .flush(flush),
    .IR_D(IR_D), .PC_D(PC_D), .PC8_D(PC8_D), .RS_D(RS_D), .RT_D(RT_D), .EXT_D(EXT_D),
    .IR_E(IR_E), .PC_E(PC_E), .PC8_E(PC8_E), .RS_E(RS_E), .RT_E(RT_E), .EXT_E(EXT_E),
    .valid_E(valid_E), .A_B_SIGN_CMP(A_B_SIGN_CMP), .A_0_SIGN_CMP(A_0_SIGN_CMP),
    .A_B_UNSIGN_CMP(A_B_UNSIGN_CMP), .bubble_cnt(bubble_cnt), .freeze_cnt(freeze_cnt));

  pipe_de_reg #(.W(W), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .freeze(freeze), .stall(stall), .flush(flush),
    .IR_D(IR_D), .PC_D(PC_D), .PC8_D(PC8_D), .RS_D(RS_D), .RT_D(RT_D), .EXT_D(EXT_D),
    .IR_E(ir4), .PC_E(pc4), .PC8_E(pc84), .RS_E(rs4), .RT_E(rt4), .EXT_E(ext4),
    .valid_E(v4), .A_B_SIGN_CMP(abs4), .A_0_SIGN_CMP(a0s4),
    .A_B_UNSIGN_CMP(abu4), .bubble_cnt(bub4), .freeze_cnt(frz4));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] cmpv(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    longint sa, sb;
    sa = sgn ? longint'($signed(a)) : longint'({32'd0, a});
    sb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
    return {sa > sb, sa == sb, sa < sb};
  endfunction

  task automatic model_zero();
    m_ir = '0; m_pc = '0; m_pc8 = '0; m_rs = '0; m_rt = '0; m_ext = '0;
    m_v = 1'b0; m_abs = '0; m_a0s = '0; m_abu = '0;
  endtask

  // Advance model by one edge, clock the DUT, compare everything.
  task automatic step();
    logic [W-1:0] b;
    if (reset) begin
      model_zero(); m_bub = 0; m_frz = 0;
    end else if (freeze) begin
      m_frz++;
    end else if (stall || flush) begin
      model_zero(); m_bub++;
    end else begin
      b = (IR_D[31:26] == 6'b001010 || IR_D[31:26] == 6'b001011) ? EXT_D : RT_D;
      m_ir = IR_D; m_pc = PC_D; m_pc8 = PC8_D; m_rs = RS_D; m_rt = RT_D; m_ext = EXT_D;
      m_v = 1'b1;
      m_abs = cmpv(RS_D, b, 1'b1);
      m_a0s = cmpv(RS_D, '0, 1'b1);
      m_abu = cmpv(RS_D, b, 1'b0);
    end
    @(posedge clk); #1;
    chk("ir_e", IR_E, m_ir);
    chk("pc_e", PC_E, m_pc);
    chk("pc8_e", PC8_E, m_pc8);
    chk("rs_e", RS_E, m_rs);
    chk("rt_e", RT_E, m_rt);
    chk("ext_e", EXT_E, m_ext);
    chk("valid_e", valid_E, m_v);
    chk("ab_sign", A_B_SIGN_CMP, m_abs);
    chk("a0_sign", A_0_SIGN_CMP, m_a0s);
    chk("ab_unsign", A_B_UNSIGN_CMP, m_abu);
    chk("bubble_cnt", bubble_cnt, m_bub);
    chk("freeze_cnt", freeze_cnt, m_frz);
    chk("bubble_cnt4", bub4, m_bub & 4'hF);
    chk("freeze_cnt4", frz4, m_frz & 4'hF);
    chk("valid_e4", v4, m_v);
  endtask

  task automatic rand_d();
    IR_D = $urandom; PC_D = $urandom; PC8_D = PC_D + 8;
    RS_D = $urandom; RT_D = $urandom; EXT_D = $urandom;
    case ($urandom_range(0, 3))
      0: IR_D[31:26] = 6'b001010;
      1: IR_D[31:26] = 6'b001011;
      2: begin IR_D[31:26] = 6'b000000; IR_D[5:0] = 6'b101010; end
      default: ;
    endcase
    if ($urandom_range(0, 3) == 0) RT_D = RS_D;
    if ($urandom_range(0, 3) == 0) EXT_D = RS_D;
    if ($urandom_range(0, 7) == 0) RS_D = '0;
  endtask

  task automatic ctl(input logic r, input logic fz, input logic st, input logic fl);
    reset = r; freeze = fz; stall = st; flush = fl;
  endtask

  initial begin
    m_bub = 0; m_frz = 0; model_zero();
    ctl(1, 0, 0, 0); rand_d();
    // reset with random D inputs
    step(); rand_d(); ctl(1, $urandom_range(0, 1), $urandom_range(0, 1), 0); step();
    chk("rst_valid", valid_E, 1'b0);
    chk("rst_ir", IR_E, 32'h0);

    // slt: -1 vs 1
    ctl(0, 0, 0, 0); rand_d();
    IR_D = {6'b000000, 5'd1, 5'd2, 5'd3, 5'd0, 6'b101010};
    RS_D = 32'hFFFF_FFFF; RT_D = 32'd1;
    step();
    chk("slt_ab_sign", A_B_SIGN_CMP, 3'b001);
    chk("slt_ab_unsign", A_B_UNSIGN_CMP, 3'b100);
    chk("slt_a0_sign", A_0_SIGN_CMP, 3'b001);

    // sltiu: equal via immediate
    rand_d();
    IR_D = {6'b001011, 5'd1, 5'd2, 16'hFFFF};
    RS_D = 32'hFFFF_FFFF; EXT_D = 32'hFFFF_FFFF; RT_D = 32'h5;
    step();
    chk("sltiu_ab_unsign", A_B_UNSIGN_CMP, 3'b010);

    // addu then stall+flush together
    rand_d();
    IR_D = {6'b000000, 5'd4, 5'd5, 5'd6, 5'd0, 6'b100001}; PC_D = 32'h3000; PC8_D = 32'h3008;
    step();
    ctl(0, 0, 1, 1); rand_d(); step();
    chk("sf_pc", PC_E, 32'h0);
    chk("sf_bub", bubble_cnt, 32'd1);
    ctl(0, 0, 0, 0); rand_d(); step();
    chk("sf_reload", valid_E, 1'b1);

    // ori at 0x3004 held by freeze with stall
    rand_d();
    IR_D = {6'b001101, 5'd1, 5'd2, 16'h1234}; PC_D = 32'h3004; PC8_D = 32'h300C;
    step();
    for (int i = 0; i < 4; i++) begin
      ctl(0, 1, 1, $urandom_range(0, 1)); rand_d(); step();
    end
    chk("frz_pc", PC_E, 32'h3004);
    chk("frz_cnt", freeze_cnt, 32'd4);
    chk("frz_bub", bubble_cnt, 32'd1);

    // reset during freeze
    ctl(1, 1, 1, 0); rand_d(); step();
    chk("rst_frz_pc", PC_E, 32'h0);
    chk("rst_frz_cnt", freeze_cnt, 32'd0);

    // 17 bubbles wrap the 4-bit counter
    ctl(0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      ctl(0, 0, $urandom_range(0, 1), 0); flush = !stall || ($urandom_range(0, 1) == 1);
      rand_d(); step();
    end
    chk("wrap_bub4", bub4, 4'd1);
    chk("wrap_bub", bubble_cnt, 32'd17);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rand_d();
      ctl($urandom_range(0, 49) == 0, $urandom_range(0, 5) == 0,
          $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
